// File: rtl/stream_window_sum_pkg.sv
// Shared definitions for the window-sum stage and its output holding register.
// Holds the stream handshake bundle, the boolean constants and the width of
// the element counter that travels alongside every emitted window sum.
package stream_window_sum_pkg;

   localparam bit true  = 1'b1;
   localparam bit false = 1'b0;

   // Width of the per-window element count (windows are at most 255 long)
   localparam int CNT_W = 8;

   // Default element width of the upstream zip-add stream
   localparam int STREAM_W = 8;

   // Stream handshake bundle: payload plus valid/ready
   typedef struct packed {
      logic [STREAM_W-1:0] data;
      logic                valid;
      logic                ready;
   } stream_t;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry output holding register for a valid/ready stream.
// A producer loads a new record whenever slot_free is high; the record is
// presented on out_data/out_valid until the consumer takes it. A load in the
// same cycle as a take overwrites the slot, so back-to-back records flow
// without a bubble.
// Ports:
//   clk, nrst        clock and synchronous active-low reset
//   load, load_data  write request and record from the producer
//   out_data         held record (keeps its value after being taken)
//   out_valid        held record is valid
//   out_ready        consumer accepts the held record
//   slot_free        a load this cycle will be stored
module stream_out_reg
   import stream_window_sum_pkg::*;
#(
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              slot_free
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;

   // The slot can be written when it is empty or is being emptied this
   // cycle. A load is only honoured when the slot is free, which keeps the
   // presented record stable while the consumer is stalling.
   always_comb begin
      slot_free = !valid_q || out_ready;
      data_d    = data_q;
      valid_d   = valid_q;
      if (load && slot_free) begin
         data_d  = load_data;
         valid_d = true;
      end else if (valid_q && out_ready) begin
         valid_d = false;
      end
   end

   // Holding register; reset empties the slot and clears the payload
   always_ff @(posedge clk) begin
      if (!nrst) begin
         data_q  <= '0;
         valid_q <= false;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;

endmodule

// File: rtl/stream_window_sum.sv
// Accumulates WINDOW consecutive elements of an unsigned input stream into a
// wider wrapping sum and emits one token per completed window, or per partial
// window when flush is pulsed. The token carries the sum and the number of
// elements it covers.
// Ports:
//   clk, nrst                       clock and synchronous active-low reset
//   sIn, sIn_valid, sIn_ready       input element stream
//   flush                           request to emit the current partial window
//   sOut, sOut_cnt                  window sum and its element count
//   sOut_valid, sOut_ready          output stream handshake
module stream_window_sum
   import stream_window_sum_pkg::*;
#(
   parameter int IN_N   = 8,
   parameter int OUT_N  = 16,
   parameter int WINDOW = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [IN_N-1:0]  sIn,
   input  logic             sIn_valid,
   output logic             sIn_ready,
   input  logic             flush,
   output logic [OUT_N-1:0] sOut,
   output logic [CNT_W-1:0] sOut_cnt,
   output logic             sOut_valid,
   input  logic             sOut_ready
);

   localparam int REC_W = OUT_N + CNT_W;
   localparam logic [CNT_W-1:0] WINDOW_CNT = CNT_W'(WINDOW);

   logic [OUT_N-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flush_pend_q, flush_pend_d;

   logic             slot_free;
   logic             accept;
   logic             flush_req;
   logic [OUT_N-1:0] sum_next;
   logic [CNT_W-1:0] cnt_next;
   logic             emit;
   logic [OUT_N-1:0] emit_sum;
   logic [CNT_W-1:0] emit_cnt;
   logic [REC_W-1:0] out_rec;

   // Window bookkeeping. Input is only taken while the output slot can
   // accept a token, so any accept is guaranteed to find room for a window
   // close or flush in the same cycle. A flush that arrives while the slot
   // is occupied is remembered and blocks input until it can be serviced,
   // so the flushed partial contains exactly the elements seen before it.
   always_comb begin
      sIn_ready    = slot_free && !flush_pend_q;
      accept       = sIn_valid && sIn_ready;
      flush_req    = flush || flush_pend_q;
      sum_next     = acc_q + OUT_N'(sIn);
      cnt_next     = cnt_q + CNT_W'(1);

      acc_d        = acc_q;
      cnt_d        = cnt_q;
      flush_pend_d = flush_pend_q;
      emit         = false;
      emit_sum     = '0;
      emit_cnt     = '0;

      if (accept) begin
         if (cnt_next == WINDOW_CNT) begin
            emit     = true;
            emit_sum = sum_next;
            emit_cnt = WINDOW_CNT;
            acc_d    = '0;
            cnt_d    = '0;
         end else begin
            acc_d = sum_next;
            cnt_d = cnt_next;
         end
      end

      // A flush after a same-cycle window close finds cnt_d already zero
      // and adds nothing; otherwise it emits the partial including any
      // element accepted this cycle.
      if (flush_req) begin
         if (slot_free) begin
            if (cnt_d != '0) begin
               emit     = true;
               emit_sum = acc_d;
               emit_cnt = cnt_d;
            end
            acc_d        = '0;
            cnt_d        = '0;
            flush_pend_d = false;
         end else begin
            flush_pend_d = true;
         end
      end
   end

   // Accumulator, element count and pending-flush state
   always_ff @(posedge clk) begin
      if (!nrst) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         flush_pend_q <= false;
      end else begin
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   stream_out_reg #(
      .DATA_W(REC_W)
   ) u_out_reg (
      .clk       (clk),
      .nrst      (nrst),
      .load      (emit),
      .load_data ({emit_sum, emit_cnt}),
      .out_data  (out_rec),
      .out_valid (sOut_valid),
      .out_ready (sOut_ready),
      .slot_free (slot_free)
   );

   assign sOut     = out_rec[REC_W-1:CNT_W];
   assign sOut_cnt = out_rec[CNT_W-1:0];

endmodule

// File: tb/tb_stream_window_sum.sv
// Self-checking bench for stream_window_sum: a table of directed cycles for
// the default WINDOW=4 instance, hand-written reset and wrap sequences, and
// a randomized run checked against a transaction-level window model.
module tb_stream_window_sum;

   logic        clk = 1'b0;
   logic        nrst;
   logic [7:0]  sIn;
   logic        sIn_valid;
   logic        sIn_ready;
   logic        flush;
   logic [15:0] sOut;
   logic [7:0]  sOut_cnt;
   logic        sOut_valid;
   logic        sOut_ready;

   // Second instance: narrow output and WINDOW=2 for wrap-around checks
   logic [7:0]  w_sIn;
   logic        w_sIn_valid;
   logic        w_sIn_ready;
   logic        w_flush;
   logic [7:0]  w_sOut;
   logic [7:0]  w_sOut_cnt;
   logic        w_sOut_valid;
   logic        w_sOut_ready;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        vin;
      logic [7:0]  din;
      logic        fl;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [15:0] e_sum;
      logic [7:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];

   int win[$];
   int exp_sum[$];
   int exp_cnt[$];
   logic        prev_hold;
   logic [15:0] prev_sum;
   logic [7:0]  prev_cnt;

   always #5 clk = ~clk;

   stream_window_sum dut (
      .clk        (clk),
      .nrst       (nrst),
      .sIn        (sIn),
      .sIn_valid  (sIn_valid),
      .sIn_ready  (sIn_ready),
      .flush      (flush),
      .sOut       (sOut),
      .sOut_cnt   (sOut_cnt),
      .sOut_valid (sOut_valid),
      .sOut_ready (sOut_ready)
   );

   stream_window_sum #(
      .IN_N   (8),
      .OUT_N  (8),
      .WINDOW (2)
   ) dut_w (
      .clk        (clk),
      .nrst       (nrst),
      .sIn        (w_sIn),
      .sIn_valid  (w_sIn_valid),
      .sIn_ready  (w_sIn_ready),
      .flush      (w_flush),
      .sOut       (w_sOut),
      .sOut_cnt   (w_sOut_cnt),
      .sOut_valid (w_sOut_valid),
      .sOut_ready (w_sOut_ready)
   );

   // Drive one cycle of inputs on the falling edge, then let outputs settle
   task automatic applyStimulus(input logic vin, input logic [7:0] din,
                                input logic fl, input logic rdy);
      @(negedge clk);
      sIn_valid  = vin;
      sIn        = din;
      flush      = fl;
      sOut_ready = rdy;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   function automatic vec_t mk(input logic vin, input int din, input logic fl,
                               input logic ordy, input logic e_ir,
                               input logic e_ov, input int e_sum,
                               input int e_cnt);
      vec_t v;
      v.vin   = vin;
      v.din   = 8'(din);
      v.fl    = fl;
      v.ordy  = ordy;
      v.e_ir  = e_ir;
      v.e_ov  = e_ov;
      v.e_sum = 16'(e_sum);
      v.e_cnt = 8'(e_cnt);
      return v;
   endfunction

   // Close the model's current window into an expected token
   task automatic pushToken();
      int s;
      s = 0;
      foreach (win[k]) s += win[k];
      exp_sum.push_back(s & 16'hFFFF);
      exp_cnt.push_back(win.size());
      win.delete();
   endtask

   // Observe the handshakes that complete at the coming rising edge and
   // advance the reference model accordingly
   task automatic observeCycle();
      if (prev_hold) begin
         checkOutput("stable sOut", 32'(sOut), 32'(prev_sum));
         checkOutput("stable sOut_cnt", 32'(sOut_cnt), 32'(prev_cnt));
      end
      if (sOut_valid && !sOut_ready)
         checkOutput("sIn_ready while blocked", 32'(sIn_ready), 32'd0);
      if (sOut_valid && sOut_ready) begin
         if (exp_sum.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected token: got sum %0d cnt %0d, expected none",
                     sOut, sOut_cnt);
         end else begin
            checkOutput("token sum", 32'(sOut), 32'(exp_sum.pop_front()));
            checkOutput("token cnt", 32'(sOut_cnt), 32'(exp_cnt.pop_front()));
         end
      end
      if (sIn_valid && sIn_ready) begin
         win.push_back(int'(sIn));
         if (win.size() == 4) pushToken();
      end
      if (flush && win.size() > 0) pushToken();
      prev_hold = sOut_valid && !sOut_ready;
      prev_sum  = sOut;
      prev_cnt  = sOut_cnt;
   endtask

   initial begin
      nrst        = 1'b0;
      sIn         = '0;
      sIn_valid   = 1'b0;
      flush       = 1'b0;
      sOut_ready  = 1'b1;
      w_sIn       = '0;
      w_sIn_valid = 1'b0;
      w_flush     = 1'b0;
      w_sOut_ready = 1'b1;
      prev_hold   = 1'b0;
      prev_sum    = '0;
      prev_cnt    = '0;

      // Reset state
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      checkOutput("reset sOut_valid", 32'(sOut_valid), 32'd0);
      checkOutput("reset sOut", 32'(sOut), 32'd0);
      checkOutput("reset sOut_cnt", 32'(sOut_cnt), 32'd0);
      checkOutput("reset sIn_ready", 32'(sIn_ready), 32'd1);
      nrst = 1'b1;

      // Per-cycle table: inputs for the cycle, outputs expected before its edge
      // Two full windows with a ready consumer
      vecs.push_back(mk(1, 1, 0, 1, 1, 0,  0, 0));
      vecs.push_back(mk(1, 2, 0, 1, 1, 0,  0, 0));
      vecs.push_back(mk(1, 3, 0, 1, 1, 0,  0, 0));
      vecs.push_back(mk(1, 4, 0, 1, 1, 0,  0, 0));
      vecs.push_back(mk(1, 5, 0, 1, 1, 1, 10, 4));
      vecs.push_back(mk(1, 6, 0, 1, 1, 0, 10, 4));
      vecs.push_back(mk(1, 7, 0, 1, 1, 0, 10, 4));
      vecs.push_back(mk(1, 8, 0, 1, 1, 0, 10, 4));
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 26, 4));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 26, 4));
      // Back-pressure for three cycles after the first window
      vecs.push_back(mk(1, 1, 0, 1, 1, 0, 26, 4));
      vecs.push_back(mk(1, 2, 0, 1, 1, 0, 26, 4));
      vecs.push_back(mk(1, 3, 0, 1, 1, 0, 26, 4));
      vecs.push_back(mk(1, 4, 0, 1, 1, 0, 26, 4));
      vecs.push_back(mk(1, 5, 0, 0, 0, 1, 10, 4));
      vecs.push_back(mk(1, 5, 0, 0, 0, 1, 10, 4));
      vecs.push_back(mk(1, 5, 0, 0, 0, 1, 10, 4));
      vecs.push_back(mk(1, 5, 0, 1, 1, 1, 10, 4));
      vecs.push_back(mk(1, 6, 0, 1, 1, 0, 10, 4));
      vecs.push_back(mk(1, 7, 0, 1, 1, 0, 10, 4));
      vecs.push_back(mk(1, 8, 0, 1, 1, 0, 10, 4));
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 26, 4));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 26, 4));
      // Flush with no input after 5,6
      vecs.push_back(mk(1, 5, 0, 1, 1, 0, 26, 4));
      vecs.push_back(mk(1, 6, 0, 1, 1, 0, 26, 4));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 26, 4));
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 11, 2));
      // Flush coincident with accepting 7 after 3,4
      vecs.push_back(mk(1, 3, 0, 1, 1, 0, 11, 2));
      vecs.push_back(mk(1, 4, 0, 1, 1, 0, 11, 2));
      vecs.push_back(mk(1, 7, 1, 1, 1, 0, 11, 2));
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 14, 3));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 14, 3));
      // Flush while the slot is blocked: pending flush holds input off
      vecs.push_back(mk(1, 1, 0, 1, 1, 0, 14, 3));
      vecs.push_back(mk(1, 1, 0, 1, 1, 0, 14, 3));
      vecs.push_back(mk(1, 1, 0, 1, 1, 0, 14, 3));
      vecs.push_back(mk(1, 1, 0, 1, 1, 0, 14, 3));
      vecs.push_back(mk(0, 0, 1, 0, 0, 1,  4, 4));
      vecs.push_back(mk(1, 9, 0, 1, 0, 1,  4, 4));
      vecs.push_back(mk(1, 9, 0, 1, 1, 0,  4, 4));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0,  4, 4));
      vecs.push_back(mk(0, 0, 0, 1, 1, 1,  9, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].vin, vecs[i].din, vecs[i].fl, vecs[i].ordy);
         checkOutput($sformatf("row %0d sIn_ready", i), 32'(sIn_ready), 32'(vecs[i].e_ir));
         checkOutput($sformatf("row %0d sOut_valid", i), 32'(sOut_valid), 32'(vecs[i].e_ov));
         checkOutput($sformatf("row %0d sOut", i), 32'(sOut), 32'(vecs[i].e_sum));
         checkOutput($sformatf("row %0d sOut_cnt", i), 32'(sOut_cnt), 32'(vecs[i].e_cnt));
      end

      // Reset while a token is held
      applyStimulus(1'b1, 8'd1, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'd2, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'd3, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'd4, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("pre-reset sOut_valid", 32'(sOut_valid), 32'd1);
      checkOutput("pre-reset sOut", 32'(sOut), 32'd10);
      nrst = 1'b0;
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      nrst = 1'b1;
      checkOutput("mid reset sOut_valid", 32'(sOut_valid), 32'd0);
      checkOutput("mid reset sOut", 32'(sOut), 32'd0);
      checkOutput("mid reset sOut_cnt", 32'(sOut_cnt), 32'd0);

      // Reset after two accepted elements discards the partial
      applyStimulus(1'b1, 8'd9, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'd9, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      nrst = 1'b0;
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      nrst = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'd1, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      checkOutput("after reset sOut_valid", 32'(sOut_valid), 32'd1);
      checkOutput("after reset sOut", 32'(sOut), 32'd4);
      checkOutput("after reset sOut_cnt", 32'(sOut_cnt), 32'd4);

      // Wrap-around on the 8-bit, WINDOW=2 instance
      @(negedge clk);
      w_sIn_valid = 1'b1;
      w_sIn = 8'd200;
      @(negedge clk);
      w_sIn = 8'd100;
      @(negedge clk);
      w_sIn = 8'd255;
      #1;
      checkOutput("wrap sOut_valid", 32'(w_sOut_valid), 32'd1);
      checkOutput("wrap sOut", 32'(w_sOut), 32'd44);
      checkOutput("wrap sOut_cnt", 32'(w_sOut_cnt), 32'd2);
      @(negedge clk);
      w_sIn = 8'd255;
      @(negedge clk);
      w_sIn_valid = 1'b0;
      #1;
      checkOutput("wrap2 sOut", 32'(w_sOut), 32'd254);
      checkOutput("wrap2 sOut_cnt", 32'(w_sOut_cnt), 32'd2);

      // Randomized run against the window model, from a clean reset
      nrst = 1'b0;
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      nrst = 1'b1;
      win.delete();
      exp_sum.delete();
      exp_cnt.delete();
      prev_hold = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                       $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
         observeCycle();
      end
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
      observeCycle();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
         observeCycle();
      end
      checkOutput("drain leftover tokens", 32'(exp_sum.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
